// File: rtl/fft_pkg.sv
// Shared FFT types: FSM state encoding, complex sample type and bit-reversal helper.
package fft_pkg;

  localparam int unsigned FFT_WIDTH = 12;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } cplx_t;

  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned nbits);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      r = {r[30:0], idx[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_butterfly_cplx.sv
// Combinational radix-2 DIT butterfly with per-stage halving: (A+W*B)/2, (A-W*B)/2.
module fft_butterfly_cplx #(
  parameter int WIDTH = 12,
  parameter int FRAC  = 10
) (
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  input  logic signed [WIDTH-1:0] w_re,
  input  logic signed [WIDTH-1:0] w_im,
  output logic signed [WIDTH-1:0] sum_re,
  output logic signed [WIDTH-1:0] sum_im,
  output logic signed [WIDTH-1:0] diff_re,
  output logic signed [WIDTH-1:0] diff_im
);

  localparam int PW = 2 * WIDTH + 1;
  localparam int SW = WIDTH + 1;

  logic signed [PW-1:0] prod_re, prod_im, sh_re, sh_im;
  logic signed [SW-1:0] p_re, p_im, s_re, s_im, d_re, d_im;
  logic                 unused_bits;

  always_comb begin
    prod_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    prod_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
    sh_re   = prod_re >>> FRAC;
    sh_im   = prod_im >>> FRAC;
    p_re    = sh_re[SW-1:0];
    p_im    = sh_im[SW-1:0];
    // Sums wrap at WIDTH+1 bits; the halving brings them back to WIDTH.
    s_re    = SW'(a_re) + p_re;
    s_im    = SW'(a_im) + p_im;
    d_re    = SW'(a_re) - p_re;
    d_im    = SW'(a_im) - p_im;
    sum_re  = s_re[SW-1:1];
    sum_im  = s_im[SW-1:1];
    diff_re = d_re[SW-1:1];
    diff_im = d_im[SW-1:1];
  end

  assign unused_bits = ^{sh_re[PW-1:SW], sh_im[PW-1:SW], s_re[0], s_im[0], d_re[0], d_im[0]};

endmodule

// File: rtl/fft_radix2_iter_engine.sv
// Iterative in-place radix-2 DIT FFT: bit-reversed load, one butterfly per cycle, natural-order unload.
module fft_radix2_iter_engine
  import fft_pkg::*;
#(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 12,
  parameter int FRAC    = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH*SAMPLES/2-1:0]   twiddle_re,
  input  logic [WIDTH*SAMPLES/2-1:0]   twiddle_im,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_re,
  input  logic [WIDTH-1:0]             in_im,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_re,
  output logic [WIDTH-1:0]             out_im,
  output logic                         out_last,
  output logic                         busy
);

  localparam int L  = $clog2(SAMPLES);
  localparam int SW = $clog2(L);
  localparam int KW = L - 1;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } sample_t;

  sample_t mem [SAMPLES];

  state_t                  state, state_nxt;
  logic [L-1:0]            load_cnt, unload_cnt;
  logic [SW-1:0]           stage;
  logic [KW-1:0]           k;
  logic                    accept, out_fire, last_bfly;
  logic [L-1:0]            ld_addr, kx, span_mask, top_idx, bot_idx;
  logic [KW-1:0]           tw_idx;
  logic [31:0]             tw_sh;
  logic signed [WIDTH-1:0] w_re, w_im;
  sample_t                 a_new, b_new;

  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_bfly = (state == COMPUTE) && (stage == SW'(L - 1)) && (k == '1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = LOAD;
      LOAD:    if (accept && load_cnt == L'(SAMPLES - 1)) state_nxt = COMPUTE;
      COMPUTE: if (last_bfly) state_nxt = UNLOAD;
      UNLOAD:  if (out_fire && out_last) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    busy      = (state == COMPUTE) || (state == UNLOAD);
    out_valid = (state == UNLOAD);
    out_last  = (state == UNLOAD) && (unload_cnt == L'(SAMPLES - 1));
    out_re    = '0;
    out_im    = '0;
    if (state == UNLOAD) begin
      out_re = mem[unload_cnt].re;
      out_im = mem[unload_cnt].im;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt   <= '0;
      unload_cnt <= '0;
      stage      <= '0;
      k          <= '0;
    end else begin
      if (accept) load_cnt <= load_cnt + L'(1);
      if (out_fire) unload_cnt <= unload_cnt + L'(1);
      if (state == COMPUTE) begin
        k <= k + KW'(1);
        if (k == '1) stage <= last_bfly ? '0 : stage + SW'(1);
      end
    end
  end

  // top clears bit 'stage' of k's position and re-inserts it as 0; bot sets that bit.
  always_comb begin
    ld_addr   = L'(bitrev(32'(load_cnt), L));
    kx        = {1'b0, k};
    span_mask = (L'(1) << stage) - L'(1);
    top_idx   = (((kx >> stage) << 1) << stage) | (kx & span_mask);
    bot_idx   = top_idx | (L'(1) << stage);
    tw_sh     = 32'(L - 1) - 32'(stage);
    tw_idx    = (k & span_mask[KW-1:0]) << tw_sh;
    w_re      = twiddle_re[32'(tw_idx) * WIDTH +: WIDTH];
    w_im      = twiddle_im[32'(tw_idx) * WIDTH +: WIDTH];
  end

  fft_butterfly_cplx #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_bfly (
    .a_re    (mem[top_idx].re),
    .a_im    (mem[top_idx].im),
    .b_re    (mem[bot_idx].re),
    .b_im    (mem[bot_idx].im),
    .w_re    (w_re),
    .w_im    (w_im),
    .sum_re  (a_new.re),
    .sum_im  (a_new.im),
    .diff_re (b_new.re),
    .diff_im (b_new.im)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) begin
        mem[ld_addr] <= {in_re, in_im};
      end else if (state == COMPUTE) begin
        mem[top_idx] <= a_new;
        mem[bot_idx] <= b_new;
      end
    end
  end

endmodule

// File: tb/tb_fft_radix2_iter_engine.sv
// Randomized self-checking bench for fft_radix2_iter_engine against a floating-free integer FFT model.
module tb_fft_radix2_iter_engine;

  localparam int S = 8;
  localparam int W = 12;
  localparam int F = 10;
  localparam int L = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [W*S/2-1:0]   twiddle_re, twiddle_im;
  logic               in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [W-1:0]       in_re, in_im, out_re, out_im;

  fft_radix2_iter_engine #(
    .SAMPLES (S),
    .WIDTH   (W),
    .FRAC    (F)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .twiddle_re (twiddle_re),
    .twiddle_im (twiddle_im),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  int tw_r [S/2] = '{1024, 724, 0, -724};
  int tw_i [S/2] = '{0, -724, -1024, -724};

  int fr_re [S], fr_im [S];
  int id_re [S], id_im [S];
  int hs_cyc;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference DFT via the textbook iterative radix-2 algorithm on integer arrays.
  function automatic void ref_fft(input int xr [S], input int xi [S], output int yr [S], output int yi [S]);
    int ar [S], ai [S];
    int rev, span, top, bot, t, pr, pi, tr0, ti0;
    for (int n = 0; n < S; n++) begin
      rev = 0;
      for (int b = 0; b < L; b++) if ((n >> b) & 1) rev += 1 << (L - 1 - b);
      ar[rev] = xr[n];
      ai[rev] = xi[n];
    end
    for (int s = 0; s < L; s++) begin
      span = 1 << s;
      for (int k = 0; k < S / 2; k++) begin
        top = (k / span) * 2 * span + (k % span);
        bot = top + span;
        t   = (k % span) * (S / (2 * span));
        pr  = (ar[bot] * tw_r[t] - ai[bot] * tw_i[t]) >>> F;
        pi  = (ar[bot] * tw_i[t] + ai[bot] * tw_r[t]) >>> F;
        tr0 = ar[top];
        ti0 = ai[top];
        ar[top] = (tr0 + pr) >>> 1;
        ai[top] = (ti0 + pi) >>> 1;
        ar[bot] = (tr0 - pr) >>> 1;
        ai[bot] = (ti0 - pi) >>> 1;
      end
    end
    yr = ar;
    yi = ai;
  endfunction

  task automatic send_frame(input bit gaps, input bit hold_valid);
    int n = 0;
    int guard = 0;
    bit hs;
    while (n < S && guard < 400) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_re    = W'($urandom);
      end else begin
        in_valid = 1'b1;
        in_re    = W'(fr_re[n]);
        in_im    = W'(fr_im[n]);
      end
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (hs) begin
        n++;
        hs_cyc = cyc;
      end
    end
    check("load_count", n, S);
    if (hold_valid) begin
      in_valid = 1'b1;
      in_re    = W'($urandom);
      in_im    = W'($urandom);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic recv_frame(input bit bp, input bit ideal_chk);
    int exp_re [S], exp_im [S];
    int m = 0;
    int guard = 0;
    bit first = 1'b1;
    bit stalled = 1'b0;
    int d;
    logic [W-1:0] st_re, st_im;
    logic st_last;
    ref_fft(fr_re, fr_im, exp_re, exp_im);
    while (m < S && guard < 400) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (first) begin
          check("latency", cyc + 1 - hs_cyc, L * S / 2 + 1);
          first = 1'b0;
        end
        if (stalled) begin
          check("hold_re", $signed(out_re), $signed(st_re));
          check("hold_im", $signed(out_im), $signed(st_im));
          check("hold_last", out_last, st_last);
        end
        check("in_ready_unload", in_ready, 0);
        check("busy_unload", busy, 1);
        if (out_ready) begin
          check("bin_re", $signed(out_re), exp_re[m]);
          check("bin_im", $signed(out_im), exp_im[m]);
          check("out_last", out_last, m == S - 1);
          if (ideal_chk) begin
            d = $signed(out_re) - id_re[m];
            check("ideal_re", (d <= 1 && d >= -1), 1);
            d = $signed(out_im) - id_im[m];
            check("ideal_im", (d <= 1 && d >= -1), 1);
          end
          m++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          st_re   = out_re;
          st_im   = out_im;
          st_last = out_last;
        end
      end else if (!first) begin
        check("valid_drop", 0, 1);
      end
      @(posedge clk); #1;
      guard++;
    end
    check("unload_count", m, S);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  task automatic rand_frame();
    for (int n = 0; n < S; n++) begin
      fr_re[n] = int'($urandom_range(0, 2800)) - 1400;
      fr_im[n] = int'($urandom_range(0, 2800)) - 1400;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_re"}, out_re, 0);
    check({tag, "_out_im"}, out_im, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b0;
    for (int i = 0; i < S / 2; i++) begin
      twiddle_re[i*W +: W] = W'(tw_r[i]);
      twiddle_im[i*W +: W] = W'(tw_i[i]);
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_to_load", in_ready, 1);

    // Impulse
    for (int n = 0; n < S; n++) begin
      fr_re[n] = (n == 0) ? 800 : 0;
      fr_im[n] = 0;
      id_re[n] = 100;
      id_im[n] = 0;
    end
    send_frame(1'b0, 1'b0);
    recv_frame(1'b0, 1'b1);

    // DC under random backpressure
    for (int n = 0; n < S; n++) begin
      fr_re[n] = 800;
      fr_im[n] = 0;
      id_re[n] = (n == 0) ? 800 : 0;
      id_im[n] = 0;
    end
    send_frame(1'b0, 1'b0);
    recv_frame(1'b1, 1'b1);

    // Alternating sign, with input gaps and in_valid held through COMPUTE
    for (int n = 0; n < S; n++) begin
      fr_re[n] = (n % 2 == 0) ? 800 : -800;
      fr_im[n] = 0;
      id_re[n] = (n == 4) ? 800 : 0;
      id_im[n] = 0;
    end
    send_frame(1'b1, 1'b1);
    recv_frame(1'b0, 1'b1);

    // Random frames with gaps and backpressure
    for (int f = 0; f < 6; f++) begin
      rand_frame();
      send_frame(1'b1, f[0]);
      recv_frame(1'b1, 1'b0);
    end

    // Reset in the middle of COMPUTE
    rand_frame();
    send_frame(1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("busy_compute", busy, 1);
    check("in_ready_compute", in_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    reset = 1'b0;
    @(posedge clk); #1;
    check("reload_ready", in_ready, 1);
    for (int n = 0; n < S; n++) begin
      fr_re[n] = (n == 0) ? 800 : 0;
      fr_im[n] = 0;
      id_re[n] = 100;
      id_im[n] = 0;
    end
    send_frame(1'b0, 1'b0);
    recv_frame(1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
